mem_bus_arbiter: RTL

- Shares the single-port memory bus between the Dcache and the Icache bank.
- Default priority goes to the Dcache. A starvation counter guarantees the Icache periodic access.
- A 15-entry tag ownership table records which requester owns each accepted load tag. Returning data tags are steered only to the owner.
- A cap on outstanding loads provides back-pressure.

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory-bus arbiter handshake bundle: memory-side bus plus the Dcache and
// Icache request/response channels. The "master" modport is the arbiter's
// view; "slave" is the view of the surrounding caches and memory.
interface mem_bus_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 4;

  // Memory side
  logic [TAG_W-1:0]  mem2ctrl_response;
  logic [DATA_W-1:0] mem2ctrl_data;
  logic [TAG_W-1:0]  mem2ctrl_tag;
  logic [ADDR_W-1:0] ctrl2mem_addr;
  logic [DATA_W-1:0] ctrl2mem_data;
  logic [1:0]        ctrl2mem_command;

  // Dcache side
  logic [1:0]        Dcache2Dmem_command;
  logic [ADDR_W-1:0] Dcache2Dmem_addr;
  logic [DATA_W-1:0] Dcache2Dmem_data;
  logic [TAG_W-1:0]  Dmem2Dcache_response;
  logic [DATA_W-1:0] Dmem2Dcache_data;
  logic [TAG_W-1:0]  Dmem2Dcache_tag;

  // Icache side
  logic [1:0]        Icache2Imem_command;
  logic [ADDR_W-1:0] Icache2Imem_addr;
  logic [TAG_W-1:0]  Imem2Icache_response;
  logic [DATA_W-1:0] Imem2Icache_data;
  logic [TAG_W-1:0]  Imem2Icache_tag;

  modport master (
    input  mem2ctrl_response, mem2ctrl_data, mem2ctrl_tag,
    output ctrl2mem_addr, ctrl2mem_data, ctrl2mem_command,
    input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
    output Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag,
    input  Icache2Imem_command, Icache2Imem_addr,
    output Imem2Icache_response, Imem2Icache_data, Imem2Icache_tag
  );

  modport slave (
    output mem2ctrl_response, mem2ctrl_data, mem2ctrl_tag,
    input  ctrl2mem_addr, ctrl2mem_data, ctrl2mem_command,
    output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
    input  Dmem2Dcache_response, Dmem2Dcache_data, Dmem2Dcache_tag,
    output Icache2Imem_command, Icache2Imem_addr,
    input  Imem2Icache_response, Imem2Icache_data, Imem2Icache_tag
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Dcache/Icache arbiter for the single-port memory bus. Dcache has default
// priority; a starvation counter force-grants the Icache. A tag ownership
// table steers returning load tags to the requester that issued them, and an
// outstanding-load cap provides back-pressure.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 4,  // >= 1
  parameter int unsigned MAX_OUTSTANDING = 8   // 1..15
) (
  input  logic                clock,
  input  logic                reset,           // async, active low
  mem_bus_arbiter_if.master   bus,
  output logic [3:0]          outstanding_cnt,
  output logic                orphan_tag
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         d_grant_cnt,
  output logic [31:0]         i_grant_cnt,
  output logic [31:0]         blocked_cycles
`endif
);

  localparam logic [1:0]  BUS_NONE  = 2'd0;
  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned SW        = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]    starve_q, starve_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      valid_q;   // entry 0 unused: tag 0 means "none"
  logic [15:0]      owner_q;   // 1 = Icache, 0 = Dcache

  logic run;
  logic load_block, d_elig, i_elig, force_i;
  logic grant_d, grant_i, grant_load;
  logic resp_nz, alloc, comp_hit, comp_miss;

  // Grant decision and table lookups; everything is idle while in reset
  always_comb begin
    run        = reset;
    load_block = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    d_elig     = run && ((bus.Dcache2Dmem_command == BUS_STORE) ||
                         ((bus.Dcache2Dmem_command == BUS_LOAD) && !load_block));
    i_elig     = run && (bus.Icache2Imem_command == BUS_LOAD) && !load_block;
    force_i    = i_elig && (starve_q == SW'(STARVE_LIMIT));
    grant_i    = force_i || (i_elig && !d_elig);
    grant_d    = d_elig && !grant_i;
    grant_load = grant_i || (grant_d && (bus.Dcache2Dmem_command == BUS_LOAD));
    resp_nz    = (bus.mem2ctrl_response != 4'd0);
    alloc      = grant_load && resp_nz;
    comp_hit   = run && (bus.mem2ctrl_tag != 4'd0) && valid_q[bus.mem2ctrl_tag];
    comp_miss  = run && (bus.mem2ctrl_tag != 4'd0) && !valid_q[bus.mem2ctrl_tag];
  end

  // Memory bus drive, accept responses and completion steering
  always_comb begin
    bus.ctrl2mem_command     = BUS_NONE;
    bus.ctrl2mem_addr        = bus.Dcache2Dmem_addr;
    bus.ctrl2mem_data        = bus.Dcache2Dmem_data;
    bus.Dmem2Dcache_response = 4'd0;
    bus.Imem2Icache_response = 4'd0;
    bus.Dmem2Dcache_data     = bus.mem2ctrl_data;
    bus.Imem2Icache_data     = bus.mem2ctrl_data;
    bus.Dmem2Dcache_tag      = 4'd0;
    bus.Imem2Icache_tag      = 4'd0;
    if (grant_i) begin
      bus.ctrl2mem_command     = BUS_LOAD;
      bus.ctrl2mem_addr        = bus.Icache2Imem_addr;
      bus.Imem2Icache_response = bus.mem2ctrl_response;
    end else if (grant_d) begin
      bus.ctrl2mem_command     = bus.Dcache2Dmem_command;
      bus.Dmem2Dcache_response = bus.mem2ctrl_response;
    end
    if (comp_hit) begin
      if (owner_q[bus.mem2ctrl_tag]) bus.Imem2Icache_tag = bus.mem2ctrl_tag;
      else                           bus.Dmem2Dcache_tag = bus.mem2ctrl_tag;
    end
  end

  assign outstanding_cnt = cnt_q;
  assign orphan_tag      = comp_miss;

  // Next outstanding count and starvation counter
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = '0;
    case ({alloc, comp_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (run && (bus.Icache2Imem_command == BUS_LOAD) && !grant_i) begin
      if (starve_q == SW'(STARVE_LIMIT)) starve_d = starve_q;
      else                               starve_d = starve_q + SW'(1);
    end
  end

  // State registers; completion clears before allocation so a reused tag
  // ends valid with its new owner
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (comp_hit) valid_q[bus.mem2ctrl_tag] <= 1'b0;
      if (alloc) begin
        valid_q[bus.mem2ctrl_response] <= 1'b1;
        owner_q[bus.mem2ctrl_response] <= grant_i;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic any_load_req;
  assign any_load_req = (bus.Dcache2Dmem_command == BUS_LOAD) ||
                        (bus.Icache2Imem_command == BUS_LOAD);

  // Saturating grant and back-pressure statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_grant_cnt    <= '0;
      i_grant_cnt    <= '0;
      blocked_cycles <= '0;
    end else begin
      if (grant_d && resp_nz && (d_grant_cnt != '1))
        d_grant_cnt <= d_grant_cnt + 32'd1;
      if (grant_i && resp_nz && (i_grant_cnt != '1))
        i_grant_cnt <= i_grant_cnt + 32'd1;
      if (load_block && any_load_req && (blocked_cycles != '1))
        blocked_cycles <= blocked_cycles + 32'd1;
    end
  end
`endif

endmodule
